// File: rtl/product_accumulator_pkg.sv
// product_accumulator_pkg: shared widths, clog2 helper and signed product/sum types
package product_accumulator_pkg;
    localparam int DEF_PROD_W = 10;
    localparam int DEF_LEN = 4;
    localparam int DEF_ACC_W = 12;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    typedef logic signed [DEF_PROD_W-1:0] prod_t;
    typedef logic signed [DEF_ACC_W-1:0] acc_t;
endpackage

// File: rtl/product_accumulator_sum_out_reg.sv
// sum_out_reg: registered group-sum output with valid/ready hold; ACC_RELU_EN clamps negative sums to 0
module sum_out_reg
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    load,
    input  logic signed [ACC_W-1:0] din,
    input  logic                    ready,
    output logic signed [ACC_W-1:0] sum,
    output logic                    valid
);
    logic signed [ACC_W-1:0] clamped;

`ifdef ACC_RELU_EN
    assign clamped = din[ACC_W-1] ? '0 : din;
`else
    assign clamped = din;
`endif

    // A closing group always wins over consumption so the new sum is never dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            sum   <= clamped;
            valid <= 1'b1;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of LEN signed products into a registered valid/ready output (ACC_RELU_EN: clamp negative sums)
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int LEN    = DEF_LEN,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic signed [PROD_W-1:0] prod,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic signed [ACC_W-1:0]  sum,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic [clog2(LEN)-1:0]    cnt
);
    localparam int CNT_W = clog2(LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    logic signed [ACC_W-1:0] acc, prod_ext, acc_next;
    logic last, xfer;

    assign last       = cnt == LAST;
    assign prod_ready = !(last && sum_valid && !sum_ready);
    assign xfer       = prod_valid && prod_ready && !clear;
    assign prod_ext   = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_next   = (cnt == '0 ? '0 : acc) + prod_ext;

    // Running partial sum and product count; the first product of a group reloads acc
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (xfer) begin
            acc <= acc_next;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

    sum_out_reg #(.ACC_W(ACC_W)) u_out (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .load  (xfer && last),
        .din   (acc_next),
        .ready (sum_ready),
        .sum   (sum),
        .valid (sum_valid)
    );
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: table-driven groups plus hand sequences, sums checked through an expected-value queue
module tb_product_accumulator;
    import product_accumulator_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, prod_valid = 1'b0, sum_ready = 1'b0;
    prod_t prod = '0;
    logic prod_ready, sum_valid;
    acc_t sum;
    logic [1:0] cnt;
    int checks = 0, failures = 0;
    acc_t exp_q[$];

    typedef struct packed {
        prod_t [3:0] p;
        acc_t s;
    } vec_t;
    vec_t vt[7];

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .sum        (sum),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .cnt        (cnt)
    );

    function automatic acc_t rl(input acc_t x);
`ifdef ACC_RELU_EN
        return x < 0 ? '0 : x;
`else
        return x;
`endif
    endfunction

    function automatic vec_t mk(input int a, input int b, input int c, input int d, input int s);
        vec_t v;
        v.p[0] = prod_t'(a);
        v.p[1] = prod_t'(b);
        v.p[2] = prod_t'(c);
        v.p[3] = prod_t'(d);
        v.s = acc_t'(s);
        return v;
    endfunction

    task automatic chk(input string n, input logic signed [31:0] a, input logic signed [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", n, a, e);
        end
    endtask

    task automatic send(input int p);
        int n;
        logic ok;
        n = 0;
        prod = prod_t'(p);
        prod_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = prod_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 20);
        prod_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=stalled exp=accepted prod=%0d", p);
        end
    endtask

    task automatic grp(input int a, input int b, input int c, input int d);
        send(a);
        send(b);
        send(c);
        send(d);
    endtask

    // Every consumed sum must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (sum_valid && sum_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sum got=%0d exp=none", sum);
            end else begin
                chk("sum_pop", $signed(sum), exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = mk(1, 2, 3, 4, 10);
        vt[1] = mk(511, 511, 511, 511, 2044);
        vt[2] = mk(-512, -512, -512, -512, -2048);
        vt[3] = mk(-240, -240, -240, -240, -960);
        vt[4] = mk(100, -101, 0, 0, -1);
        vt[5] = mk(-100, 50, 25, 26, 1);
        vt[6] = mk(0, 0, 0, 0, 0);

        #12;
        chk("rst_ready", prod_ready, 1);
        chk("rst_valid", sum_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("rst_sum", $signed(sum), 0);
        chk("rst_cnt", cnt, 0);

        sum_ready = 1'b1;
        exp_q.push_back(rl(86));
        send(100);
        send(-30);
        chk("basic_cnt2", cnt, 2);
        send(256);
        send(-240);
        chk("basic_valid", sum_valid, 1);
        chk("basic_sum", $signed(sum), 86);
        chk("basic_cnt0", cnt, 0);
        @(posedge clk) #1;
        chk("basic_one_cycle", sum_valid, 0);
        chk("basic_sum_kept", $signed(sum), 86);

        sum_ready = 1'b0;
        exp_q.push_back(1024);
        exp_q.push_back(1024);
        grp(256, 256, 256, 256);
        chk("bp_valid", sum_valid, 1);
        chk("bp_sum", $signed(sum), 1024);
        send(256);
        send(256);
        send(256);
        chk("bp_cnt3", cnt, 3);
        prod = prod_t'(256);
        prod_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall", prod_ready, 0);
        chk("bp_sum_stable", $signed(sum), 1024);
        @(posedge clk) #1;
        @(negedge clk);
        chk("bp_stall2", prod_ready, 0);
        chk("bp_cnt_hold", cnt, 3);
        @(posedge clk) #1;
        sum_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", prod_ready, 1);
        @(posedge clk) #1;
        sum_ready = 1'b0;
        prod_valid = 1'b0;
        chk("bp_valid2", sum_valid, 1);
        chk("bp_sum2", $signed(sum), 1024);
        chk("bp_cnt_wrap", cnt, 0);
        @(posedge clk) #1;
        chk("bp_hold2", sum_valid, 1);
        sum_ready = 1'b1;
        @(posedge clk) #1;
        chk("bp_drained", sum_valid, 0);

        sum_ready = 1'b0;
        grp(1, 1, 1, 1);
        chk("clrv_valid", sum_valid, 1);
        chk("clrv_sum", $signed(sum), 4);
        clear = 1'b1;
        @(posedge clk) #1;
        clear = 1'b0;
        chk("clrv_dropped", sum_valid, 0);
        chk("clrv_sum_kept", $signed(sum), 4);
        sum_ready = 1'b1;

        send(50);
        send(60);
        chk("clr_cnt2", cnt, 2);
        clear = 1'b1;
        prod = prod_t'(77);
        prod_valid = 1'b1;
        @(posedge clk) #1;
        clear = 1'b0;
        prod_valid = 1'b0;
        chk("clr_cnt0", cnt, 0);
        chk("clr_valid0", sum_valid, 0);
        exp_q.push_back(rl(10));
        grp(1, 2, 3, 4);
        chk("clr_sum", $signed(sum), 10);
        chk("clr_valid", sum_valid, 1);
        @(posedge clk) #1;

        send(5);
        send(6);
        chk("arst_cnt2", cnt, 2);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", cnt, 0);
        chk("arst_valid", sum_valid, 0);
        chk("arst_sum", $signed(sum), 0);
        chk("arst_ready", prod_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        exp_q.push_back(rl(-64));
        grp(-16, -16, -16, -16);
        chk("arst_sum_grp", $signed(sum), rl(-64));
        chk("arst_valid_grp", sum_valid, 1);
        @(posedge clk) #1;

        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(rl(vt[i].s));
            grp(vt[i].p[0], vt[i].p[1], vt[i].p[2], vt[i].p[3]);
            chk("tbl_cnt", cnt, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        chk("final_valid", sum_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
